hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the RISC-V 32IM core: sole producer of the stall, bubble, flush and hold strobes consumed by the PC register, the IF/ID register, the ID/EX register (`id_ex_bubble_i`, `id_ex_flush_en`, and hold on the next revision) and the EX/MEM register. It detects load-use hazards and EX-resolved control redirects. It also sequences multi-cycle M-extension (MUL/DIV) operations with a two-state FSM, a watchdog and a saturating stall-cycle counter.

## Interface
Parameters:
- `CNT_W`, 32: width of the stall-cycle counter.
- `MDU_TIMEOUT`, 64: maximum MDU_WAIT cycles before the watchdog releases the stall. Legal range is 2..255.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `id_rs1_addr_i` input 5: rs1 of the instruction in ID.
- `id_rs2_addr_i` input 5: rs2 of the instruction in ID.
- `id_uses_rs1_i` input 1: the ID instruction reads rs1.
- `id_uses_rs2_i` input 1: the ID instruction reads rs2.
- `ex_mem_read_i` input 1: the EX instruction is a load.
- `ex_rd_addr_i` input 5: rd of the EX instruction.
- `ex_redirect_i` input 1: a taken branch, JAL or JALR was resolved in EX this cycle.
- `ex_mdu_req_i` input 1: a valid MUL/DIV instruction is in EX.
- `mdu_done_i` input 1: the MDU result is valid this cycle.
- `pc_stall_o` output 1: hold the PC.
- `if_id_stall_o` output 1: hold IF/ID.
- `if_id_flush_o` output 1: clear IF/ID to a NOP.
- `id_ex_bubble_o` output 1: load a NOP into ID/EX.
- `id_ex_flush_en_o` output 1: clear ID/EX (wrong path).
- `id_ex_hold_o` output 1: hold ID/EX contents.
- `ex_mem_bubble_o` output 1: load a NOP into EX/MEM.
- `mdu_timeout_o` output 1: sticky flag, set when the watchdog has fired.
- `stall_cnt_o` output CNT_W: saturating count of cycles in which `pc_stall_o` = 1.

## Operation
- The FSM has two states, RUN and MDU_WAIT. All strobe outputs are Mealy: combinational from the state and the current inputs.
- Load-use condition (LU): `ex_mem_read_i` & `ex_rd_addr_i` != 0 & ((`id_uses_rs1_i` & rs1 == rd) | (`id_uses_rs2_i` & rs2 == rd)).

RUN, evaluated in priority order:
1. `ex_redirect_i`: `if_id_flush_o` = 1 and `id_ex_flush_en_o` = 1. All stall outputs = 0. LU is ignored because the ID instruction is on the wrong path. The FSM stays in RUN even if `ex_mdu_req_i` is also high.
2. `ex_mdu_req_i` & !`mdu_done_i`: `pc_stall_o`, `if_id_stall_o`, `id_ex_hold_o` and `ex_mem_bubble_o` = 1. Next state is MDU_WAIT and the watchdog counter is cleared.
3. `ex_mdu_req_i` & `mdu_done_i` (single-cycle result): no strobes asserted; the FSM stays in RUN.
4. LU: `pc_stall_o`, `if_id_stall_o` and `id_ex_bubble_o` = 1.
5. Otherwise: all strobes = 0.

MDU_WAIT:
- `mdu_done_i` = 1: all strobes = 0 so the pipeline advances that cycle. Next state is RUN.
- Otherwise, if the watchdog count equals MDU_TIMEOUT-1: all strobes = 0, `mdu_timeout_o` is set (sticky), and the next state is RUN.
- Otherwise: the same four strobes as RUN rule 2 are asserted and the watchdog count increments.
- `ex_redirect_i` and LU are ignored in this state.

Other rules:
- `id_ex_bubble_o` and `id_ex_hold_o` are never asserted together.
- `stall_cnt_o` increments on each rising edge where `pc_stall_o` = 1. It saturates at 2^CNT_W-1 and does not wrap.
- While `rst_n` = 0, all strobe outputs are forced to 0 regardless of inputs.

## Timing
- Reset is asynchronous. It sets the state to RUN, the watchdog count to 0, `stall_cnt_o` to 0 and `mdu_timeout_o` to 0. All strobes read 0 during reset.
- Strobe latency is 0 cycles: a strobe is valid in the same cycle as the inputs that cause it. State, the watchdog count and `stall_cnt_o` update on the rising edge.
- A load-use hazard produces exactly one stall cycle. On the next cycle the bubble is in EX, `ex_mem_read_i` = 0, and LU clears.
- An MDU operation whose `mdu_done_i` arrives N cycles after entering EX (N ≥ 1) stalls for exactly N cycles. With done in the same cycle (N = 0) there is no stall.
- The watchdog bounds an MDU stall to MDU_TIMEOUT cycles, counting the RUN entry cycle.
- If reset is asserted in MDU_WAIT, the FSM returns to RUN immediately and the strobes drop asynchronously.

## Test plan
- Load-use: lw x5 in EX, add x6,x5,x1 in ID (rs1 = 5, uses_rs1 = 1) -> exactly one cycle with `pc_stall_o`, `if_id_stall_o` and `id_ex_bubble_o` = 1; `stall_cnt_o` = 1 afterwards. The same case with rd = x0 -> no stall.
- Redirect with LU true simultaneously -> `if_id_flush_o` = 1, `id_ex_flush_en_o` = 1, `pc_stall_o` = 0, and the FSM stays in RUN.
- DIV with `mdu_done_i` 5 cycles after `ex_mdu_req_i` -> `id_ex_hold_o` and `ex_mem_bubble_o` high for 5 cycles, low in the done cycle; `stall_cnt_o` = 5.
- MUL with `mdu_done_i` in the same cycle as `ex_mdu_req_i` -> no strobes asserted, state remains RUN.
- `mdu_done_i` never asserted, MDU_TIMEOUT = 8 -> stall lasts 8 cycles, then `mdu_timeout_o` = 1 and stays high until reset.
- Counter saturation with CNT_W = 4: 20 consecutive stall cycles -> `stall_cnt_o` = 15. Also: `rst_n` dropped mid-MDU_WAIT -> strobes go to 0 immediately, and all counters and flags are 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for the RV32IM core. Sole producer of the
//   stall / bubble / flush / hold strobes for the PC, IF/ID, ID/EX and EX/MEM
//   registers. It detects load-use hazards and EX-resolved redirects. It also
//   sequences multi-cycle MUL/DIV operations with a RUN/MDU_WAIT FSM, a
//   watchdog and a saturating stall-cycle counter.
//
//   All strobes are Mealy outputs: combinational from the state and the
//   current inputs, with zero latency. They are forced low while rst_n is low.
//
// Ports
//   clk, rst_n        : clock (rising edge) and asynchronous active-low reset
//   id_rs1_addr_i     : rs1 of the ID instruction
//   id_rs2_addr_i     : rs2 of the ID instruction
//   id_uses_rs1_i     : the ID instruction reads rs1
//   id_uses_rs2_i     : the ID instruction reads rs2
//   ex_mem_read_i     : the EX instruction is a load
//   ex_rd_addr_i      : rd of the EX instruction
//   ex_redirect_i     : a taken branch or jump was resolved in EX this cycle
//   ex_mdu_req_i      : a valid MUL/DIV instruction is in EX
//   mdu_done_i        : the MDU result is valid this cycle
//   pc_stall_o        : hold the PC
//   if_id_stall_o     : hold IF/ID
//   if_id_flush_o     : clear IF/ID to a NOP
//   id_ex_bubble_o    : load a NOP into ID/EX
//   id_ex_flush_en_o  : clear ID/EX (wrong path)
//   id_ex_hold_o      : hold the ID/EX contents
//   ex_mem_bubble_o   : load a NOP into EX/MEM
//   mdu_timeout_o     : sticky flag, set when the watchdog has fired
//   stall_cnt_o       : saturating count of cycles with pc_stall_o high
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64   // legal range 2..255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_redirect_i,
  input  logic             ex_mdu_req_i,
  input  logic             mdu_done_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             id_ex_flush_en_o,
  output logic             id_ex_hold_o,
  output logic             ex_mem_bubble_o,
  output logic             mdu_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int              WD_W    = 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic lu;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic id_ex_bubble_c, id_ex_flush_en_c, id_ex_hold_c, ex_mem_bubble_c;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Load-use: a load in EX writes a non-zero register that ID reads.
  assign lu = ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
              ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
               (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));

  always_comb begin
    state_d          = state_q;
    wd_d             = wd_q;
    timeout_d        = timeout_q;
    pc_stall_c       = 1'b0;
    if_id_stall_c    = 1'b0;
    if_id_flush_c    = 1'b0;
    id_ex_bubble_c   = 1'b0;
    id_ex_flush_en_c = 1'b0;
    id_ex_hold_c     = 1'b0;
    ex_mem_bubble_c  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (ex_redirect_i) begin
          // The ID instruction is on the wrong path, so LU and any MDU
          // request are ignored.
          if_id_flush_c    = 1'b1;
          id_ex_flush_en_c = 1'b1;
        end else if (ex_mdu_req_i && !mdu_done_i) begin
          // The entry cycle already counts as one stall cycle, so the
          // watchdog starts from zero in MDU_WAIT.
          pc_stall_c      = 1'b1;
          if_id_stall_c   = 1'b1;
          id_ex_hold_c    = 1'b1;
          ex_mem_bubble_c = 1'b1;
          wd_d            = '0;
          state_d         = MDU_WAIT;
        end else if (ex_mdu_req_i) begin
          // Single-cycle MDU result: the pipeline simply advances.
        end else if (lu) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done_i) begin
          state_d = RUN;
        end else if (wd_q == WD_LAST) begin
          // Release the stall so a hung MDU cannot lock up the core.
          timeout_d = 1'b1;
          state_d   = RUN;
        end else begin
          pc_stall_c      = 1'b1;
          if_id_stall_c   = 1'b1;
          id_ex_hold_c    = 1'b1;
          ex_mem_bubble_c = 1'b1;
          wd_d            = wd_q + WD_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Strobes read 0 while reset is asserted, regardless of the inputs.
  assign pc_stall_o       = rst_n & pc_stall_c;
  assign if_id_stall_o    = rst_n & if_id_stall_c;
  assign if_id_flush_o    = rst_n & if_id_flush_c;
  assign id_ex_bubble_o   = rst_n & id_ex_bubble_c;
  assign id_ex_flush_en_o = rst_n & id_ex_flush_en_c;
  assign id_ex_hold_o     = rst_n & id_ex_hold_c;
  assign ex_mem_bubble_o  = rst_n & ex_mem_bubble_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      if (pc_stall_o) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign mdu_timeout_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed testbench for hazard_ctrl (CNT_W = 4, MDU_TIMEOUT = 8).
//   Inputs change on the falling edge. Mealy strobes are sampled 1 ns later,
//   and registered outputs are sampled after the rising edge has passed.
//   The strobe vector is packed as
//   {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_flush_en,
//    id_ex_hold, ex_mem_bubble}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam int CNT_W       = 4;
  localparam int MDU_TIMEOUT = 8;

  localparam logic [6:0] S_NONE = 7'b000_0000;
  localparam logic [6:0] S_LU   = 7'b110_1000;
  localparam logic [6:0] S_MDU  = 7'b110_0011;
  localparam logic [6:0] S_RDR  = 7'b001_0100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic             id_uses_rs1_i, id_uses_rs2_i, ex_mem_read_i;
  logic             ex_redirect_i, ex_mdu_req_i, mdu_done_i;
  logic             pc_stall_o, if_id_stall_o, if_id_flush_o;
  logic             id_ex_bubble_o, id_ex_flush_en_o, id_ex_hold_o;
  logic             ex_mem_bubble_o, mdu_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [6:0]       strb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .MDU_TIMEOUT(MDU_TIMEOUT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs1_addr_i    (id_rs1_addr_i),
    .id_rs2_addr_i    (id_rs2_addr_i),
    .id_uses_rs1_i    (id_uses_rs1_i),
    .id_uses_rs2_i    (id_uses_rs2_i),
    .ex_mem_read_i    (ex_mem_read_i),
    .ex_rd_addr_i     (ex_rd_addr_i),
    .ex_redirect_i    (ex_redirect_i),
    .ex_mdu_req_i     (ex_mdu_req_i),
    .mdu_done_i       (mdu_done_i),
    .pc_stall_o       (pc_stall_o),
    .if_id_stall_o    (if_id_stall_o),
    .if_id_flush_o    (if_id_flush_o),
    .id_ex_bubble_o   (id_ex_bubble_o),
    .id_ex_flush_en_o (id_ex_flush_en_o),
    .id_ex_hold_o     (id_ex_hold_o),
    .ex_mem_bubble_o  (ex_mem_bubble_o),
    .mdu_timeout_o    (mdu_timeout_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  assign strb = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
                 id_ex_flush_en_o, id_ex_hold_o, ex_mem_bubble_o};

  // Sets every DUT input except rst_n.
  task automatic drive(input logic mr, input logic [4:0] rd,
                       input logic u1, input logic [4:0] r1,
                       input logic u2, input logic [4:0] r2,
                       input logic rdr, input logic req, input logic done);
    ex_mem_read_i = mr;  ex_rd_addr_i  = rd;
    id_uses_rs1_i = u1;  id_rs1_addr_i = r1;
    id_uses_rs2_i = u2;  id_rs2_addr_i = r2;
    ex_redirect_i = rdr; ex_mdu_req_i  = req; mdu_done_i = done;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    // Stimulus that would otherwise stall, so the strobe gating is visible.
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL reset_strb got=%b exp=%b", strb, S_NONE);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (stall_cnt_o !== 4'd0) begin
      n_bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt_o);
    end
    n_cmp++;
    if (mdu_timeout_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_timeout got=%b exp=0", mdu_timeout_o);
    end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    // lw x5 in EX, add x6,x5,x1 in ID
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (strb !== S_LU) begin
      n_bad++; $display("FAIL lu_rs1 got=%b exp=%b", strb, S_LU);
    end
    // The bubble is now in EX.
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL lu_clear got=%b exp=%b", strb, S_NONE);
    end
    n_cmp++;
    if (stall_cnt_o !== 4'd1) begin
      n_bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt_o);
    end
    // Load to x0: no hazard.
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL lu_x0 got=%b exp=%b", strb, S_NONE);
    end
    // rs1 matches, but the ID instruction does not read rs1.
    @(negedge clk);
    drive(1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL lu_unused got=%b exp=%b", strb, S_NONE);
    end
    // rs2 match.
    @(negedge clk);
    drive(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (strb !== S_LU) begin
      n_bad++; $display("FAIL lu_rs2 got=%b exp=%b", strb, S_LU);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (stall_cnt_o !== 4'd2) begin
      n_bad++; $display("FAIL lu_cnt2 got=%0d exp=2", stall_cnt_o);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    // Redirect, LU and MDU request are all high at once.
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (strb !== S_RDR) begin
      n_bad++; $display("FAIL redirect got=%b exp=%b", strb, S_RDR);
    end
    // Still in RUN: idle inputs give no strobes.
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL redirect_run got=%b exp=%b", strb, S_NONE);
    end
    n_cmp++;
    if (stall_cnt_o !== 4'd0) begin
      n_bad++; $display("FAIL redirect_cnt got=%0d exp=0", stall_cnt_o);
    end
  endtask

  task automatic test_mdu_multi();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      // Redirect and LU in MDU_WAIT must be ignored.
      if (c == 2) drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      else        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (strb !== S_MDU) begin
        n_bad++; $display("FAIL div_stall_c%0d got=%b exp=%b", c, strb, S_MDU);
      end
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL div_done got=%b exp=%b", strb, S_NONE);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL div_after got=%b exp=%b", strb, S_NONE);
    end
    n_cmp++;
    if (stall_cnt_o !== 4'd5) begin
      n_bad++; $display("FAIL div_cnt got=%0d exp=5", stall_cnt_o);
    end
  endtask

  task automatic test_mdu_single();
    do_reset();
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL mul_single got=%b exp=%b", strb, S_NONE);
    end
    // LU is honoured on the next cycle only if the FSM is still in RUN.
    @(negedge clk);
    drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (strb !== S_LU) begin
      n_bad++; $display("FAIL mul_run got=%b exp=%b", strb, S_LU);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (stall_cnt_o !== 4'd1) begin
      n_bad++; $display("FAIL mul_cnt got=%0d exp=1", stall_cnt_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < MDU_TIMEOUT; c++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (strb !== S_MDU) begin
        n_bad++; $display("FAIL wd_stall_c%0d got=%b exp=%b", c, strb, S_MDU);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL wd_release got=%b exp=%b", strb, S_NONE);
    end
    n_cmp++;
    if (mdu_timeout_o !== 1'b0) begin
      n_bad++; $display("FAIL wd_early got=%b exp=0", mdu_timeout_o);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (mdu_timeout_o !== 1'b1) begin
      n_bad++; $display("FAIL wd_flag got=%b exp=1", mdu_timeout_o);
    end
    n_cmp++;
    if (stall_cnt_o !== 4'd8) begin
      n_bad++; $display("FAIL wd_cnt got=%0d exp=8", stall_cnt_o);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (mdu_timeout_o !== 1'b1) begin
      n_bad++; $display("FAIL wd_sticky got=%b exp=1", mdu_timeout_o);
    end
  endtask

  // Runs straight after test_timeout, so the flag and counter start non-zero.
  task automatic test_reset_mid_wait();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    end
    #1;
    n_cmp++;
    if (strb !== S_MDU) begin
      n_bad++; $display("FAIL rstw_pre got=%b exp=%b", strb, S_MDU);
    end
    // Assert reset mid-cycle with the request still high.
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL rstw_strb got=%b exp=%b", strb, S_NONE);
    end
    n_cmp++;
    if (stall_cnt_o !== 4'd0) begin
      n_bad++; $display("FAIL rstw_cnt got=%0d exp=0", stall_cnt_o);
    end
    n_cmp++;
    if (mdu_timeout_o !== 1'b0) begin
      n_bad++; $display("FAIL rstw_flag got=%b exp=0", mdu_timeout_o);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (strb !== S_NONE) begin
      n_bad++; $display("FAIL rstw_run got=%b exp=%b", strb, S_NONE);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      if (c == 15) begin
        n_cmp++;
        if (stall_cnt_o !== 4'd15) begin
          n_bad++; $display("FAIL sat_reach got=%0d exp=15", stall_cnt_o);
        end
      end
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (stall_cnt_o !== 4'd15) begin
      n_bad++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_mdu_multi();
    test_mdu_single();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout reached 100000 ns without completing");
    $fatal(1, "simulation time limit");
  end

endmodule
